gcd_sequencer: RTL and testbench



---
 rtl/gcd_pkg.sv | 17 +
 rtl/gcd_sequencer_if.sv | 36 +++
 rtl/gcd_iter_cnt.sv | 41 ++++
 rtl/gcd_sequencer.sv | 139 +++++++++++++
 tb/tb_gcd_sequencer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD sequencing controller.
//   gcd_state_e : controller state encoding (3-bit).
//   GCD_WIDTH   : default operand/data bus width.
package gcd_pkg;

   localparam int unsigned GCD_WIDTH = 16;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StLoadA = 3'd1,
      StLoadB = 3'd2,
      StCalc  = 3'd3,
      StDone  = 3'd4,
      StErr   = 3'd5
   } gcd_state_e;

endpackage

// File: rtl/gcd_sequencer_if.sv
// Bundle of request handshake and datapath control signals of the GCD sequencer.
//   master : requester / datapath side (drives start, operands, comparator flags)
//   slave  : the sequencer (drives strobes, load bus, status and iteration count)
interface gcd_sequencer_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 16
);
   // request side
   logic             start;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic             busy;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] iter_cnt;
   // datapath side
   logic             lt;
   logic             gt;
   logic             eq;
   logic             ldA;
   logic             ldB;
   logic             sel1;
   logic             sel2;
   logic             sel_in;
   logic [WIDTH-1:0] data_in;

   modport master (
      output start, opa, opb, lt, gt, eq,
      input  busy, done, err, iter_cnt, ldA, ldB, sel1, sel2, sel_in, data_in
   );

   modport slave (
      input  start, opa, opb, lt, gt, eq,
      output busy, done, err, iter_cnt, ldA, ldB, sel1, sel2, sel_in, data_in
   );
endinterface

// File: rtl/gcd_iter_cnt.sv
// Saturating iteration counter for the GCD sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero the count (wins over inc)
//   inc        : add one, holding at all-ones
//   cnt        : current count
//   at_limit   : cnt equals MAX_ITER (watchdog compare)
module gcd_iter_cnt #(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned MAX_ITER = 65535
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             at_limit
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt      = cnt_q;
   assign at_limit = (32'(cnt_q) == MAX_ITER);

endmodule

// File: rtl/gcd_sequencer.sv
// Sequencing controller for a subtract-and-compare GCD datapath.
// Accepts an operand pair on start (IDLE only), loads A then B over the shared bus,
// then steps the subtractor once per cycle until the comparator reports A==B.
// The result is left in datapath register A. A zero operand is rejected with err.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : gcd_sequencer_if.slave (handshake, operands, comparator flags,
//                datapath strobes, load bus, busy/done/err, iter_cnt)
// Build option: define GCD_WATCHDOG_EN to abort with err once iter_cnt reaches MAX_ITER.
module gcd_sequencer
   import gcd_pkg::*;
#(
   parameter int unsigned WIDTH    = GCD_WIDTH,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned MAX_ITER = 65535
) (
   input  logic            clk,
   input  logic            rst_n,
   gcd_sequencer_if.slave  bus
);

   gcd_state_e       state_q, state_d;
   logic [WIDTH-1:0] opa_q, opb_q;
   logic             accept;
   logic             calc_eq, calc_lt, calc_gt;
   logic             wd_hit;
   logic             cnt_inc;

   // eq > lt > gt; no flag at all is treated as equal so the loop always exits.
   assign calc_eq = bus.eq | ~(bus.lt | bus.gt);
   assign calc_lt = ~bus.eq & bus.lt;
   assign calc_gt = ~bus.eq & ~bus.lt & bus.gt;

   assign accept  = (state_q == StIdle) && bus.start && (bus.opa != '0) && (bus.opb != '0);
   assign cnt_inc = (state_q == StCalc) && !wd_hit && (calc_lt || calc_gt);

`ifdef GCD_WATCHDOG_EN
   logic at_limit;
   assign wd_hit = at_limit && !bus.eq;
`else
   assign wd_hit = 1'b0;
`endif

   gcd_iter_cnt #(
      .CNT_W    (CNT_W),
      .MAX_ITER (MAX_ITER)
   ) u_iter_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (accept),
      .inc      (cnt_inc),
      .cnt      (bus.iter_cnt),
`ifdef GCD_WATCHDOG_EN
      .at_limit (at_limit)
`else
      .at_limit ()
`endif
   );

   // State and captured operands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         opa_q   <= '0;
         opb_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            opa_q <= bus.opa;
            opb_q <= bus.opb;
         end
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = accept ? StLoadA : StErr;
            end
         end
         StLoadA: state_d = StLoadB;
         StLoadB: state_d = StCalc;
         StCalc: begin
            if (wd_hit) begin
               state_d = StErr;
            end else if (calc_eq) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      bus.ldA     = 1'b0;
      bus.ldB     = 1'b0;
      bus.sel1    = 1'b0;
      bus.sel2    = 1'b0;
      bus.sel_in  = 1'b0;
      bus.data_in = '0;
      bus.done    = 1'b0;
      bus.err     = 1'b0;
      bus.busy    = (state_q != StIdle);
      unique case (state_q)
         StLoadA: begin
            bus.sel_in  = 1'b1;
            bus.data_in = opa_q;
            bus.ldA     = 1'b1;
         end
         StLoadB: begin
            bus.sel_in  = 1'b1;
            bus.data_in = opb_q;
            bus.ldB     = 1'b1;
         end
         StCalc: begin
            if (!wd_hit) begin
               if (calc_lt) begin
                  // B <= B - A
                  bus.sel1 = 1'b1;
                  bus.ldB  = 1'b1;
               end else if (calc_gt) begin
                  // A <= A - B
                  bus.sel2 = 1'b1;
                  bus.ldA  = 1'b1;
               end
            end
         end
         StDone:  bus.done = 1'b1;
         StErr:   bus.err  = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_gcd_sequencer.sv
// Self-checking bench for gcd_sequencer: behavioural datapath, arithmetic GCD reference,
// directed and randomized operand pairs.
module tb_gcd_sequencer;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned CNT_W = 8;
`ifdef GCD_WATCHDOG_EN
   localparam int unsigned MAX_ITER = 3;
   localparam bit          WD       = 1'b1;
`else
   localparam int unsigned MAX_ITER = 65535;
   localparam bit          WD       = 1'b0;
`endif
   localparam int SAT = (1 << CNT_W) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   gcd_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   gcd_sequencer #(
      .WIDTH    (WIDTH),
      .CNT_W    (CNT_W),
      .MAX_ITER (MAX_ITER)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural datapath: two registers, subtractor, comparator (not reset).
   logic [WIDTH-1:0] dp_a = '0;
   logic [WIDTH-1:0] dp_b = '0;
   logic [WIDTH-1:0] dp_bus;

   assign bus.lt = (dp_a < dp_b);
   assign bus.gt = (dp_a > dp_b);
   assign bus.eq = (dp_a == dp_b);

   always_comb begin
      dp_bus = bus.sel_in ? bus.data_in
                          : ((bus.sel1 ? dp_b : dp_a) - (bus.sel2 ? dp_b : dp_a));
   end

   always @(posedge clk) begin
      if (bus.ldA) dp_a <= dp_bus;
      if (bus.ldB) dp_b <= dp_bus;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void model_gcd(input int a, input int b, output int g, output int n);
      n = 0;
      while (a != b) begin
         if (a < b) b = b - a;
         else       a = a - b;
         n++;
      end
      g = a;
   endfunction

   // One request: accept at edge E0, then watch every cycle until done/err.
   // k counts negedges after E0, so done is expected at k = steps + 3.
   task automatic run_op(input int a, input int b, input bit poke);
      int         g, n, exp_k, exp_iter, k, gaps, step_bad;
      bit         exp_err, ld_seen, timed_out, zero_op;
      logic [4:0] got_v, exp_v;
      string      t;
      t        = $sformatf("op(%0d,%0d)", a, b);
      g        = 0;
      n        = 0;
      exp_err  = 1'b0;
      exp_iter = 0;
      zero_op  = (a == 0) || (b == 0);
      if (zero_op) begin
         exp_err = 1'b1;
         exp_k   = 0;
      end else begin
         model_gcd(a, b, g, n);
         exp_k    = n + 3;
         exp_iter = (n > SAT) ? SAT : n;
         if (WD && (n > int'(MAX_ITER))) begin
            exp_err  = 1'b1;
            exp_k    = int'(MAX_ITER) + 3;
            exp_iter = int'(MAX_ITER);
         end
      end

      @(negedge clk);
      bus.start = 1'b1;
      bus.opa   = WIDTH'(a);
      bus.opb   = WIDTH'(b);
      @(negedge clk);
      bus.start = 1'b0;
      bus.opa   = WIDTH'($urandom);  // captured copies must be used from here on
      bus.opb   = WIDTH'($urandom);

      k = 0; gaps = 0; step_bad = 0; ld_seen = 1'b0; timed_out = 1'b0;
      while (!(bus.done || bus.err)) begin
         if (!bus.busy) gaps++;
         if (bus.ldA || bus.ldB) ld_seen = 1'b1;
         if (k == 0) begin
            check({t, " load_a strobes"}, 32'({bus.ldA, bus.ldB, bus.sel_in}), 32'b101);
            check({t, " load_a data"}, 32'(bus.data_in), 32'(a));
         end else if (k == 1) begin
            check({t, " load_b strobes"}, 32'({bus.ldA, bus.ldB, bus.sel_in}), 32'b011);
            check({t, " load_b data"}, 32'(bus.data_in), 32'(b));
         end else begin
            got_v = {bus.ldA, bus.ldB, bus.sel1, bus.sel2, bus.sel_in};
            if (dp_a == dp_b || (WD && (k - 2) >= int'(MAX_ITER))) exp_v = 5'b00000;
            else if (dp_a < dp_b)                                  exp_v = 5'b01100;
            else                                                   exp_v = 5'b10010;
            if (got_v !== exp_v) step_bad++;
         end
         bus.start = (poke && k == 4);
         if (poke && k == 4) begin
            bus.opa = 16'd3;
            bus.opb = 16'd9;
         end
         if (k > exp_k + 20) begin
            timed_out = 1'b1;
            break;
         end
         @(negedge clk);
         k++;
      end
      bus.start = 1'b0;
      if (bus.ldA || bus.ldB) ld_seen = 1'b1;

      check({t, " timeout"}, 32'(timed_out), 32'd0);
      check({t, " latency"}, 32'(k), 32'(exp_k));
      check({t, " done"}, 32'(bus.done), 32'(!exp_err));
      check({t, " err"}, 32'(bus.err), 32'(exp_err));
      check({t, " busy_gaps"}, 32'(gaps), 32'd0);
      if (zero_op) begin
         check({t, " no_load"}, 32'(ld_seen), 32'd0);
      end else begin
         check({t, " calc_steps"}, 32'(step_bad), 32'd0);
         check({t, " iter_cnt"}, 32'(bus.iter_cnt), 32'(exp_iter));
         if (!exp_err) check({t, " result"}, 32'(dp_a), 32'(g));
      end
      @(negedge clk);
      check({t, " idle_after"}, 32'({bus.busy, bus.done, bus.err}), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      int k;
      int a, b;
      bus.start = 1'b0;
      bus.opa   = '0;
      bus.opb   = '0;
      #1;
      check("reset outs", 32'({bus.busy, bus.done, bus.err, bus.ldA, bus.ldB,
                               bus.sel1, bus.sel2, bus.sel_in}), 32'd0);
      check("reset iter_cnt", 32'(bus.iter_cnt), 32'd0);
      check("reset data_in", 32'(bus.data_in), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op(48, 18, 1'b0);
      run_op(7, 7, 1'b0);
      run_op(0, 5, 1'b0);
      run_op(1071, 462, 1'b1);
      run_op(9, 0, 1'b0);
      run_op(300, 1, 1'b0);   // saturates the narrow counter in the default build

      // Asynchronous reset in the middle of CALC
      @(negedge clk);
      bus.start = 1'b1;
      bus.opa   = 16'd48;
      bus.opb   = 16'd18;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst outs", 32'({bus.busy, bus.done, bus.err, bus.ldA, bus.ldB,
                                   bus.sel1, bus.sel2, bus.sel_in}), 32'd0);
      check("async_rst iter_cnt", 32'(bus.iter_cnt), 32'd0);
      check("async_rst data_in", 32'(bus.data_in), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(12, 8, 1'b0);

      // Held start re-triggers from IDLE on the edge after DONE
      @(negedge clk);
      bus.start = 1'b1;
      bus.opa   = 16'd9;
      bus.opb   = 16'd6;
      k = 0;
      while (!bus.done && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("retrig first_done", 32'(bus.done), 32'd1);
      @(negedge clk);
      check("retrig idle_gap", 32'(bus.busy), 32'd0);
      @(negedge clk);
      check("retrig reload", 32'({bus.busy, bus.ldA}), 32'b11);
      bus.start = 1'b0;
      k = 0;
      while (!bus.done && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("retrig second_done", 32'(bus.done), 32'd1);
      check("retrig result", 32'(dp_a), 32'd3);
      @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         a = $urandom_range(1, 255);
         b = $urandom_range(1, 255);
         if (i % 5 == 4) begin
            if ($urandom_range(0, 1) == 0) a = 0;
            else                           b = 0;
         end
         run_op(a, b, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
